operand_bypass_unit: RTL and testbench
======================================

# operand_bypass_unit

Parametrised operand-source and forwarding unit for the ID→EX boundary of the pipelined CPU. It flops register-file read data into ID_EX and tracks destination/write-enable/load status of the instructions in EX, DM and WB. From that tracking it generates its own bypass selects, so decode no longer supplies them. It also flags load-use hazards, snoops WB writes into held operands during stalls, and drives the src0/src1 busses and the pipelined store data.

## Interface
- DATA_W, 16, datapath width (≥ 12)
- RF_AW, 4, register address width
- ZERO_REG, 1, 1 = register 0 is hard-zero: never bypassed, never hazards
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- stall_ID_EX  in  1  hold ID_EX stage
- stall_EX_DM  in  1  hold EX_DM and DM_WB stages; 1 implies stall_ID_EX=1
- flush_ID_EX  in  1  insert bubble into ID_EX
- p0, p1  in  DATA_W  RF read data (ID)
- p0_addr, p1_addr  in  RF_AW  RF read addresses (ID)
- re0, re1  in  1  port actually used by the ID instruction
- we_ID  in  1  ID instruction writes a register
- dst_addr_ID  in  RF_AW  its destination
- ld_ID  in  1  ID instruction is a load
- src0sel_ID_EX, src1sel_ID_EX  in  2  source selects (already EX-aligned)
- imm_ID_EX  in  12  immediate field
- pc_ID_EX  in  DATA_W  next PC for JAL
- dst_EX_DM  in  DATA_W  result of instruction in DM
- dst_DM_WB  in  DATA_W  result of instruction in WB (also RF write data)
- src0, src1  out  DATA_W  source busses
- p0_EX_DM  out  DATA_W  store data
- load_use_hazard  out  1  ID must hold one cycle; combinational

## Operation
- Tracking per stage {we, dst_addr, ld}: ID_EX, EX_DM, DM_WB. ID_EX also holds {p0_addr, p1_addr, re0, re1} and operand regs op0, op1.
- ID_EX advance (!stall_ID_EX): load tracking from ID inputs. op0 ← dst_DM_WB if DM_WB.we and DM_WB.dst_addr==p0_addr (write-through, excluding reg 0), else p0; likewise op1. If flush_ID_EX or load_use_hazard: we, ld, re0, re1 loaded as 0 (bubble), operands don't-care.
- ID_EX hold (stall_ID_EX): tracking held. Snoop: if DM_WB.we and its dst matches p0_addr_ID_EX, op0 ← dst_DM_WB. Same for op1.
- EX_DM: !stall_EX_DM loads ID_EX tracking, or a bubble if stall_ID_EX=1. stall_EX_DM holds.
- DM_WB: !stall_EX_DM loads EX_DM tracking; otherwise holds.
- EX bypass per port n:
  - Match = re_n, stage we, dst == src addr, and not (ZERO_REG and addr 0).
  - Priority: EX_DM match → dst_EX_DM; DM_WB match → dst_DM_WB; else op_n. Result is RF_pn.
- load_use_hazard = ID_EX.we & ID_EX.ld & ((re0 & p0_addr==ID_EX.dst) | (re1 & p1_addr==ID_EX.dst)), with the reg-0 exclusion. Forced 0 when stall_ID_EX.
- p0_EX_DM ← RF_p0 when !stall_EX_DM.
- src0 by src0sel_ID_EX:
  - 0 → RF_p0
  - 1 → sext(imm[8:0])
  - 2 → sext(imm[11:0])
  - 3 → sext(imm[3:0])
  - All sign-extended to DATA_W.
- src1 by src1sel_ID_EX:
  - 0 → RF_p1
  - 1 → pc_ID_EX
  - 2 or 3 → sext(imm[7:0])

## Timing
- Reset: all tracking we/ld/re = 0, addresses 0, op0/op1 = 0, p0_EX_DM = 0. load_use_hazard = 0 while ID_EX.ld = 0.
- Operand latency: RF read in ID cycle N, on src bus in cycle N+1. Bypass paths are combinational in EX.
- Load-use: hazard high during the consumer's ID cycle. The next cycle has a bubble in EX, and the consumer gets the load data via dst_DM_WB when it reaches EX.
- Simultaneous EX_DM and DM_WB matches: EX_DM wins.
- Flush and hazard in the same cycle: single bubble.
- Async reset mid-stall: tracking clears immediately and no stale bypass remains.

## Test plan
- Back-to-back ALU: I1 writes R3=0x1234 (in DM), I2 reads R3 on port 0 with src0sel=0 → src0=0x1234 via dst_EX_DM, p0_EX_DM=0x1234 next edge.
- Double match: R5 written by DM (0xAAAA) and WB (0x5555) → src1=0xAAAA. Then DM bubble → src1=0x5555.
- Load-use: LW R2 in EX, ID reads R2 → load_use_hazard=1 one cycle. After the bubble, src0 = dst_DM_WB load data (0xBEEF).
- Stall snoop: hold stall_ID_EX 3 cycles while the producer of R7 retires through WB with 0x0042 → after release, src0=0x0042 from op0.
- Reg 0: DM writes R0=0xFFFF, EX reads R0 with p0=0 → src0=0, no hazard on a load to R0.
- Immediates: imm=0x9F3, src0sel=1..3 → 0xFFF3, 0xF9F3, 0x0003. src1sel=2 → 0xFFF3, src1sel=1 → pc_ID_EX. Async reset asserted mid-run → p0_EX_DM=0 immediately.

Source files
------------

// File: rtl/operand_bypass_unit.sv
// rtl/operand_bypass_unit.sv - ID->EX operand capture, forwarding, load-use detection and source muxing
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   stall_ID_EX, stall_EX_DM      stage holds (stall_EX_DM implies stall_ID_EX)
//   flush_ID_EX                   replace the advancing ID instruction with a bubble
//   p0, p1, p0_addr, p1_addr      register-file read data and addresses from ID
//   re0, re1                      ID instruction actually uses read port 0 / 1
//   we_ID, dst_addr_ID, ld_ID     ID instruction write-enable, destination, load flag
//   src0sel_ID_EX, src1sel_ID_EX  EX-aligned source selects
//   imm_ID_EX, pc_ID_EX           EX-aligned immediate field and next PC
//   dst_EX_DM, dst_DM_WB          results of the instructions in DM and WB
//   src0, src1                    EX source busses
//   p0_EX_DM                      store data pipelined into DM
//   load_use_hazard               ID must hold one cycle (combinational)

module operand_bypass_unit #(
    parameter int DATA_W   = 16,
    parameter int RF_AW    = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_ID_EX,
    input  logic              stall_EX_DM,
    input  logic              flush_ID_EX,
    input  logic [DATA_W-1:0] p0,
    input  logic [DATA_W-1:0] p1,
    input  logic [RF_AW-1:0]  p0_addr,
    input  logic [RF_AW-1:0]  p1_addr,
    input  logic              re0,
    input  logic              re1,
    input  logic              we_ID,
    input  logic [RF_AW-1:0]  dst_addr_ID,
    input  logic              ld_ID,
    input  logic [1:0]        src0sel_ID_EX,
    input  logic [1:0]        src1sel_ID_EX,
    input  logic [11:0]       imm_ID_EX,
    input  logic [DATA_W-1:0] pc_ID_EX,
    input  logic [DATA_W-1:0] dst_EX_DM,
    input  logic [DATA_W-1:0] dst_DM_WB,
    output logic [DATA_W-1:0] src0,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] p0_EX_DM,
    output logic              load_use_hazard
);

    // ID_EX tracking and captured operands
    logic              we_ie, ld_ie, re0_ie, re1_ie;
    logic [RF_AW-1:0]  dst_ie, p0a_ie, p1a_ie;
    logic [DATA_W-1:0] op0, op1;

    // Later stages only need write tracking: load data is already on
    // dst_DM_WB by the time a dependent instruction can reach EX.
    logic              we_ed, we_dw;
    logic [RF_AW-1:0]  dst_ed, dst_dw;

    logic              ex_m0, ex_m1, dw_m0, dw_m1;
    logic              wt0, wt1, snoop0, snoop1;
    logic              bubble_ie;
    logic [DATA_W-1:0] rf_p0, rf_p1;

    function automatic logic hard_zero(input logic [RF_AW-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // EX bypass matches; EX_DM is younger, so it wins over DM_WB
    assign ex_m0 = re0_ie && we_ed && (dst_ed == p0a_ie) && !hard_zero(p0a_ie);
    assign ex_m1 = re1_ie && we_ed && (dst_ed == p1a_ie) && !hard_zero(p1a_ie);
    assign dw_m0 = re0_ie && we_dw && (dst_dw == p0a_ie) && !hard_zero(p0a_ie);
    assign dw_m1 = re1_ie && we_dw && (dst_dw == p1a_ie) && !hard_zero(p1a_ie);

    assign rf_p0 = ex_m0 ? dst_EX_DM : (dw_m0 ? dst_DM_WB : op0);
    assign rf_p1 = ex_m1 ? dst_EX_DM : (dw_m1 ? dst_DM_WB : op1);

    // The RF read in ID does not yet see the WB write of the same cycle
    assign wt0 = we_dw && (dst_dw == p0_addr) && !hard_zero(p0_addr);
    assign wt1 = we_dw && (dst_dw == p1_addr) && !hard_zero(p1_addr);

    // A held EX instruction must not miss producers retiring through WB
    assign snoop0 = we_dw && (dst_dw == p0a_ie) && !hard_zero(p0a_ie);
    assign snoop1 = we_dw && (dst_dw == p1a_ie) && !hard_zero(p1a_ie);

    assign load_use_hazard = !stall_ID_EX && we_ie && ld_ie && !hard_zero(dst_ie) &&
                             ((re0 && (p0_addr == dst_ie)) || (re1 && (p1_addr == dst_ie)));

    // Flush and hazard together still make exactly one bubble
    assign bubble_ie = flush_ID_EX || load_use_hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_ie    <= 1'b0;
            ld_ie    <= 1'b0;
            re0_ie   <= 1'b0;
            re1_ie   <= 1'b0;
            dst_ie   <= '0;
            p0a_ie   <= '0;
            p1a_ie   <= '0;
            op0      <= '0;
            op1      <= '0;
            we_ed    <= 1'b0;
            dst_ed   <= '0;
            we_dw    <= 1'b0;
            dst_dw   <= '0;
            p0_EX_DM <= '0;
        end else begin
            if (!stall_ID_EX) begin
                we_ie  <= we_ID && !bubble_ie;
                ld_ie  <= ld_ID && !bubble_ie;
                re0_ie <= re0 && !bubble_ie;
                re1_ie <= re1 && !bubble_ie;
                dst_ie <= dst_addr_ID;
                p0a_ie <= p0_addr;
                p1a_ie <= p1_addr;
                op0    <= wt0 ? dst_DM_WB : p0;
                op1    <= wt1 ? dst_DM_WB : p1;
            end else begin
                if (snoop0) op0 <= dst_DM_WB;
                if (snoop1) op1 <= dst_DM_WB;
            end

            if (!stall_EX_DM) begin
                // A held EX instruction sends a bubble forward
                we_ed    <= we_ie && !stall_ID_EX;
                dst_ed   <= dst_ie;
                we_dw    <= we_ed;
                dst_dw   <= dst_ed;
                p0_EX_DM <= rf_p0;
            end
        end
    end

    always_comb begin
        src0 = rf_p0;
        case (src0sel_ID_EX)
            2'd0:    src0 = rf_p0;
            2'd1:    src0 = DATA_W'($signed(imm_ID_EX[8:0]));
            2'd2:    src0 = DATA_W'($signed(imm_ID_EX[11:0]));
            default: src0 = DATA_W'($signed(imm_ID_EX[3:0]));
        endcase
    end

    always_comb begin
        src1 = rf_p1;
        case (src1sel_ID_EX)
            2'd0:    src1 = rf_p1;
            2'd1:    src1 = pc_ID_EX;
            default: src1 = DATA_W'($signed(imm_ID_EX[7:0]));
        endcase
    end

endmodule

// File: tb/tb_operand_bypass_unit.sv
// tb/tb_operand_bypass_unit.sv - randomized program-order reference bench for operand_bypass_unit

module tb_operand_bypass_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_ID_EX, stall_EX_DM, flush_ID_EX;
    logic [15:0] p0, p1;
    logic [3:0]  p0_addr, p1_addr;
    logic        re0, re1, we_ID, ld_ID;
    logic [3:0]  dst_addr_ID;
    logic [1:0]  src0sel_ID_EX, src1sel_ID_EX;
    logic [11:0] imm_ID_EX;
    logic [15:0] pc_ID_EX, dst_EX_DM, dst_DM_WB;
    logic [15:0] src0, src1, p0_EX_DM;
    logic        load_use_hazard;

    always #5 clk = ~clk;

    operand_bypass_unit #(.DATA_W(16), .RF_AW(4), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst),
        .stall_ID_EX(stall_ID_EX), .stall_EX_DM(stall_EX_DM), .flush_ID_EX(flush_ID_EX),
        .p0(p0), .p1(p1), .p0_addr(p0_addr), .p1_addr(p1_addr),
        .re0(re0), .re1(re1), .we_ID(we_ID), .dst_addr_ID(dst_addr_ID), .ld_ID(ld_ID),
        .src0sel_ID_EX(src0sel_ID_EX), .src1sel_ID_EX(src1sel_ID_EX),
        .imm_ID_EX(imm_ID_EX), .pc_ID_EX(pc_ID_EX),
        .dst_EX_DM(dst_EX_DM), .dst_DM_WB(dst_DM_WB),
        .src0(src0), .src1(src1), .p0_EX_DM(p0_EX_DM), .load_use_hazard(load_use_hazard)
    );

    typedef struct packed {
        logic        valid;
        logic        we;
        logic        ld;
        logic        re0;
        logic        re1;
        logic [3:0]  dst;
        logic [3:0]  r0;
        logic [3:0]  r1;
        logic [15:0] res;
        logic [15:0] v0;
        logic [15:0] v1;
        logic [1:0]  s0;
        logic [1:0]  s1;
        logic [11:0] imm;
        logic [15:0] pc;
    } instr_t;

    int n_chk  = 0;
    int n_pass = 0;

    instr_t      m_ex, m_dm, m_wb, id;
    bit          id_pend;
    logic [15:0] rf  [16];   // architectural RF as written by retiring instructions
    logic [15:0] srf [16];   // program-order view: updated when an instruction issues
    bit          p0_known;
    logic [15:0] p0_exp;
    logic        s_id, s_ex, fl, exp_haz;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] sext(input logic [11:0] imm, input int bits);
        int v;
        v = int'(imm) % (1 << bits);
        if (v >= (1 << (bits - 1))) v = v - (1 << bits);
        return 16'(v);
    endfunction

    function automatic instr_t gen();
        instr_t i;
        i       = '0;
        i.valid = 1'b1;
        i.we    = ($urandom_range(0, 9) < 7);
        i.ld    = i.we && ($urandom_range(0, 3) == 0);
        i.dst   = 4'($urandom_range(0, 7));
        i.r0    = 4'($urandom_range(0, 7));
        i.r1    = 4'($urandom_range(0, 7));
        i.re0   = ($urandom_range(0, 9) < 8);
        i.re1   = ($urandom_range(0, 9) < 8);
        i.res   = 16'($urandom);
        i.s0    = $urandom_range(0, 1) ? 2'd0 : 2'($urandom_range(1, 3));
        i.s1    = $urandom_range(0, 1) ? 2'd0 : 2'($urandom_range(1, 3));
        i.imm   = 12'($urandom);
        i.pc    = 16'($urandom);
        return i;
    endfunction

    function automatic instr_t bubble();
        instr_t b;
        b       = gen();
        b.valid = 1'b0;
        b.we    = 1'b0;
        b.ld    = 1'b0;
        b.re0   = 1'b0;
        b.re1   = 1'b0;
        return b;
    endfunction

    task automatic reset_model();
        m_ex     = bubble();
        m_dm     = bubble();
        m_wb     = bubble();
        id_pend  = 0;
        p0_known = 1;
        p0_exp   = 16'h0000;
        for (int k = 0; k < 16; k++) srf[k] = rf[k];
    endtask

    task automatic drive();
        s_ex = ($urandom_range(0, 9) == 0);
        s_id = s_ex || ($urandom_range(0, 9) == 0);
        fl   = ($urandom_range(0, 19) == 0);
        if (!id_pend) begin
            id      = gen();
            id_pend = 1;
        end
        stall_EX_DM   = s_ex;
        stall_ID_EX   = s_id;
        flush_ID_EX   = fl;
        p0_addr       = id.r0;
        p1_addr       = id.r1;
        p0            = rf[id.r0];
        p1            = rf[id.r1];
        re0           = id.re0;
        re1           = id.re1;
        we_ID         = id.we;
        ld_ID         = id.ld;
        dst_addr_ID   = id.dst;
        src0sel_ID_EX = m_ex.s0;
        src1sel_ID_EX = m_ex.s1;
        imm_ID_EX     = m_ex.imm;
        pc_ID_EX      = m_ex.pc;
        // load data is not available until the load reaches WB
        dst_EX_DM     = (m_dm.valid && !m_dm.ld) ? m_dm.res : 16'($urandom);
        dst_DM_WB     = m_wb.valid ? m_wb.res : 16'($urandom);
    endtask

    task automatic check_outputs();
        exp_haz = !s_id && m_ex.valid && m_ex.we && m_ex.ld && (m_ex.dst != 4'd0) &&
                  ((id.re0 && id.r0 == m_ex.dst) || (id.re1 && id.r1 == m_ex.dst));
        check("load_use_hazard", {15'b0, load_use_hazard}, {15'b0, exp_haz});
        case (m_ex.s0)
            2'd0: if (m_ex.valid && m_ex.re0) check("src0_reg", src0, m_ex.v0);
            2'd1: check("src0_imm9", src0, sext(m_ex.imm, 9));
            2'd2: check("src0_imm12", src0, sext(m_ex.imm, 12));
            default: check("src0_imm4", src0, sext(m_ex.imm, 4));
        endcase
        case (m_ex.s1)
            2'd0: if (m_ex.valid && m_ex.re1) check("src1_reg", src1, m_ex.v1);
            2'd1: check("src1_pc", src1, m_ex.pc);
            default: check("src1_imm8", src1, sext(m_ex.imm, 8));
        endcase
        if (p0_known) check("p0_EX_DM", p0_EX_DM, p0_exp);
    endtask

    task automatic advance_model();
        if (m_wb.valid && m_wb.we && m_wb.dst != 4'd0) rf[m_wb.dst] = m_wb.res;
        if (!s_ex) begin
            p0_known = m_ex.valid && m_ex.re0;
            p0_exp   = m_ex.v0;
            m_wb     = m_dm;
            m_dm     = s_id ? bubble() : m_ex;
        end
        if (!s_id) begin
            if (fl) begin
                m_ex    = bubble();
                id_pend = 0;
            end else if (exp_haz) begin
                m_ex = bubble();
            end else begin
                id.v0 = srf[id.r0];
                id.v1 = srf[id.r1];
                if (id.we && id.dst != 4'd0) srf[id.dst] = id.res;
                m_ex    = id;
                id_pend = 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        stall_ID_EX = 0; stall_EX_DM = 0; flush_ID_EX = 0;
        p0 = 16'h1111; p1 = 16'h2222; p0_addr = 4'd3; p1_addr = 4'd3;
        re0 = 1; re1 = 1; we_ID = 1; ld_ID = 1; dst_addr_ID = 4'd3;
        src0sel_ID_EX = 0; src1sel_ID_EX = 0; imm_ID_EX = 12'h000; pc_ID_EX = 16'h1357;
        dst_EX_DM = 16'hAAAA; dst_DM_WB = 16'h5555;
        rf[0] = 16'h0000;
        for (int k = 1; k < 16; k++) rf[k] = 16'($urandom);

        #12;
        check("reset_src0", src0, 16'h0000);
        check("reset_src1", src1, 16'h0000);
        check("reset_p0_EX_DM", p0_EX_DM, 16'h0000);
        check("reset_hazard", {15'b0, load_use_hazard}, 16'h0000);

        imm_ID_EX = 12'h9F3;
        src0sel_ID_EX = 2'd1; #1 check("imm_sel1", src0, 16'hFFF3);
        src0sel_ID_EX = 2'd2; #1 check("imm_sel2", src0, 16'hF9F3);
        src0sel_ID_EX = 2'd3; #1 check("imm_sel3", src0, 16'h0003);
        src1sel_ID_EX = 2'd2; #1 check("imm8_sel2", src1, 16'hFFF3);
        src1sel_ID_EX = 2'd3; #1 check("imm8_sel3", src1, 16'hFFF3);
        src1sel_ID_EX = 2'd1; #1 check("pc_sel1", src1, 16'h1357);

        @(posedge clk);
        #1 rst = 1'b0;
        reset_model();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive();
            if (cyc == 1500) begin
                stall_EX_DM = 1'b1;
                stall_ID_EX = 1'b1;
                #2 rst = 1'b1;
                #1;
                check("areset_p0_EX_DM", p0_EX_DM, 16'h0000);
                check("areset_hazard", {15'b0, load_use_hazard}, 16'h0000);
                reset_model();
                @(posedge clk);
                #1 rst = 1'b0;
                continue;
            end
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            #1;
            advance_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
